down_counter: RTL and testbench

- Loadable, parameterised down-counter/timer; the counting-direction counterpart of the team's free-running mod-N up-counter.
- Counts a loaded value down to zero on enable ticks. It emits a one-cycle terminal-count pulse and either stops (one-shot) or reloads (auto-reload).
- Used as a programmable interval/timeout generator next to the up-counter in control datapaths.

---
 rtl/down_counter.sv | 60 ++++++
 tb/tb_down_counter.sv | 117 +++++++++++
 2 files changed

// File: rtl/down_counter.sv
// down_counter: loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
module down_counter #(
  parameter int Counter_bit = 4,
  parameter int Reset_value = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic [Counter_bit-1:0] load_val,
  input  logic                   en,
  input  logic                   auto_reload,
  output logic [Counter_bit-1:0] C_out,
  output logic                   tc,
  output logic                   busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [Counter_bit-1:0] RV  = Counter_bit'(Reset_value);
  localparam logic [Counter_bit-1:0] ONE = Counter_bit'(1);
  state_t state, state_nx;
  logic [Counter_bit-1:0] cnt_nx, reload_reg, reload_nx;
  logic tc_nx;
  always_comb begin
    state_nx  = state;
    cnt_nx    = C_out;
    reload_nx = reload_reg;
    tc_nx     = 1'b0;
    if (clear) begin
      cnt_nx   = RV;
      state_nx = IDLE;
    end else if (load) begin
      reload_nx = load_val;
      cnt_nx    = load_val;
      state_nx  = (load_val != '0) ? RUN : IDLE;
      tc_nx     = (load_val == '0);
    end else if (state == RUN && en) begin
      if (C_out == ONE) begin
        tc_nx    = 1'b1;
        cnt_nx   = auto_reload ? reload_reg : '0;
        state_nx = auto_reload ? RUN : IDLE;
      end else if (C_out > ONE) begin
        cnt_nx = C_out - ONE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      C_out      <= RV;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nx;
      C_out      <= cnt_nx;
      reload_reg <= reload_nx;
      tc         <= tc_nx;
    end
  end
  assign busy = (state == RUN);
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: randomized and directed checks of down_counter against a behavioural timer model.
module tb_down_counter;
  logic clk = 1'b0, rst = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] C_out;
  logic tc, busy;
  int checks = 0, failures = 0;
  int m_cnt = 0, m_reload = 0, m_run = 0, m_tc = 0;
  int n;
  down_counter #(.Counter_bit(4), .Reset_value(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .auto_reload(auto_reload), .C_out(C_out), .tc(tc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_run = 0; m_tc = 0;
  endtask
  task automatic step(input bit c, input bit l, input int lv, input bit e, input bit ar);
    m_tc = 0;
    if (c) begin
      m_cnt = 0; m_run = 0;
    end else if (l) begin
      m_reload = lv; m_cnt = lv; m_run = (lv != 0); m_tc = (lv == 0);
    end else if (m_run == 1 && e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (ar) m_cnt = m_reload;
        else begin m_cnt = 0; m_run = 0; end
      end else m_cnt = m_cnt - 1;
    end
  endtask
  task automatic cyc(input bit c, input bit l, input int lv, input bit e, input bit ar);
    clear = c; load = l; load_val = 4'(lv); en = e; auto_reload = ar;
    @(posedge clk);
    step(c, l, lv, e, ar);
    #1;
    chk("cnt", int'(C_out), m_cnt);
    chk("tc", int'(tc), m_tc);
    chk("busy", int'(busy), m_run);
  endtask
  initial begin
    for (int i = 0; i < 6; i++) begin
      clear = 1'($urandom); load = 1'($urandom); load_val = 4'($urandom);
      en = 1'($urandom); auto_reload = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_cnt", int'(C_out), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst = 1'b1;
    model_reset();
    cyc(0, 0, 0, 1, 0);
    chk("post_rst_tc", int'(tc), 0);
    cyc(0, 1, 13, 0, 0);
    for (int i = 1; i <= 13; i++) cyc(0, 0, 0, 1, 0);
    chk("os_tc13", int'(tc), 1);
    chk("os_busy13", int'(busy), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("os_hold", int'(C_out), 0);
    cyc(0, 1, 3, 0, 1);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 1);
      n += int'(tc);
      chk("ar_busy", int'(busy), 1);
    end
    chk("ar_tcs", n, 3);
    cyc(0, 1, 5, 0, 0);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, i % 2 == 1, 0);
      if (tc && n == 0) n = i;
    end
    chk("gap_tc_cycle", n, 9);
    cyc(0, 1, 9, 1, 0);
    chk("load_en", int'(C_out), 9);
    cyc(1, 1, 6, 1, 0);
    chk("clr_load_cnt", int'(C_out), 0);
    chk("clr_load_busy", int'(busy), 0);
    cyc(0, 1, 0, 0, 0);
    chk("zero_tc", int'(tc), 1);
    cyc(0, 0, 0, 1, 0);
    chk("zero_tc_once", int'(tc), 0);
    cyc(0, 1, 15, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    chk("max_nowrap", int'(C_out), 0);
    cyc(0, 1, 4, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 7, 1, 0);
    chk("reload_mid", int'(C_out), 7);
    chk("reload_mid_tc", int'(tc), 0);
    cyc(0, 1, 10, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk("pre_async", int'(C_out), 6);
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", int'(C_out), 0);
    chk("async_busy", int'(busy), 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    cyc(0, 0, 0, 1, 0);
    chk("async_no_tc", int'(tc), 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 15),
          $urandom_range(0, 9) < 7, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
